// File: rtl/song_sequencer_pkg.sv
// Shared constants, ROM word layout and FSM state encodings for the song sequencer.
package song_sequencer_pkg;

  localparam int unsigned NOTE_W = 6;
  localparam int unsigned DUR_W  = 6;
  localparam int unsigned SONG_W = 2;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned ADDR_W = SONG_W + IDX_W;
  localparam int unsigned ROM_W  = NOTE_W + DUR_W;

  localparam logic [DUR_W-1:0] END_MARKER = '0;
  localparam logic [IDX_W-1:0] IDX_LAST   = '1;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StFetch    = 3'd1;
  localparam logic [2:0] StRomWait  = 3'd2;
  localparam logic [2:0] StLoad     = 3'd3;
  localparam logic [2:0] StWaitDone = 3'd4;
  localparam logic [2:0] StFinish   = 3'd5;
  localparam logic [2:0] StEnd      = 3'd6;

  // ROM word: note in the upper field, duration in beats in the lower field.
  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } rom_word_t;

  function automatic logic is_end_marker(input rom_word_t w);
    return w.dur == END_MARKER;
  endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Control/note-load bundle between the song sequencer, its controller and the note player.
interface song_sequencer_if;
  import song_sequencer_pkg::*;

  logic              play;
  logic [SONG_W-1:0] song;
  logic              done_with_note;
  logic [NOTE_W-1:0] note_to_load;
  logic [DUR_W-1:0]  duration_to_load;
  logic              load_new_note;
  logic              song_done;
  logic [IDX_W-1:0]  note_idx;
  // Song memory load port.
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [ROM_W-1:0]  rom_wdata;

  modport master (
    output play, song, done_with_note, rom_we, rom_waddr, rom_wdata,
    input  note_to_load, duration_to_load, load_new_note, song_done, note_idx
  );

  modport slave (
    input  play, song, done_with_note, rom_we, rom_waddr, rom_wdata,
    output note_to_load, duration_to_load, load_new_note, song_done, note_idx
  );

endinterface

// File: rtl/song_sequencer_rom.sv
// Song memory: 4 songs x 32 (note, duration) words, one-cycle registered read.
module song_sequencer_rom
  import song_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [ROM_W-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [ROM_W-1:0]  o_rdata
);

  logic [ROM_W-1:0] r_mem [2**ADDR_W];
  logic [ROM_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/song_sequencer.sv
// Steps through a song in memory, handing one note at a time to the note player.
// Define SONG_LOOP_EN to make a finished song restart while play stays high.
module song_sequencer
  import song_sequencer_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  song_sequencer_if.slave bus
);

  logic [2:0]        r_state, w_state_d;
  logic [SONG_W-1:0] r_song, w_song_d;
  logic [IDX_W-1:0]  r_idx, w_idx_d;
  logic [NOTE_W-1:0] r_note, w_note_d;
  logic [DUR_W-1:0]  r_dur, w_dur_d;
  logic [ROM_W-1:0]  w_rom_data;
  rom_word_t         w_rom_word;
  logic              w_song_change;
  logic              w_load;
  logic              w_song_done;

  song_sequencer_rom u_rom (
    .clk     (clk),
    .i_we    (bus.rom_we),
    .i_waddr (bus.rom_waddr),
    .i_wdata (bus.rom_wdata),
    .i_raddr ({r_song, r_idx}),
    .o_rdata (w_rom_data)
  );

  assign w_rom_word    = rom_word_t'(w_rom_data);
  assign w_song_change = (r_state != StIdle) && (bus.song != r_song);

  always_comb begin
    w_state_d   = r_state;
    w_song_d    = r_song;
    w_idx_d     = r_idx;
    w_note_d    = r_note;
    w_dur_d     = r_dur;
    w_load      = 1'b0;
    w_song_done = 1'b0;
    // A song change outranks everything, including a pending done_with_note.
    if (w_song_change) begin
      w_state_d = StFetch;
      w_song_d  = bus.song;
      w_idx_d   = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.play) begin
            w_song_d  = bus.song;
            w_state_d = StFetch;
          end
        end
        StFetch: begin
          if (bus.play) w_state_d = StRomWait;
        end
        StRomWait: begin
          if (bus.play) begin
            if (is_end_marker(w_rom_word)) begin
              w_state_d = StFinish;
            end else begin
              w_note_d  = w_rom_word.note;
              w_dur_d   = w_rom_word.dur;
              w_state_d = StLoad;
            end
          end
        end
        StLoad: begin
          if (bus.play) begin
            w_load    = 1'b1;
            w_state_d = StWaitDone;
          end
        end
        StWaitDone: begin
          // The note player pauses itself, so play is not consulted here.
          if (bus.done_with_note) begin
            if (r_idx == IDX_LAST) begin
              w_state_d = StFinish;
            end else begin
              w_idx_d   = r_idx + 1'b1;
              w_state_d = StFetch;
            end
          end
        end
        StFinish: begin
          w_song_done = 1'b1;
          w_idx_d     = '0;
`ifdef SONG_LOOP_EN
          w_state_d   = StFetch;
`else
          w_state_d   = StEnd;
`endif
        end
        StEnd: begin
          if (!bus.play) w_state_d = StIdle;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_song  <= '0;
      r_idx   <= '0;
      r_note  <= '0;
      r_dur   <= '0;
    end else begin
      r_state <= w_state_d;
      r_song  <= w_song_d;
      r_idx   <= w_idx_d;
      r_note  <= w_note_d;
      r_dur   <= w_dur_d;
    end
  end

  assign bus.note_to_load     = r_note;
  assign bus.duration_to_load = r_dur;
  assign bus.load_new_note    = w_load;
  assign bus.song_done        = w_song_done;
  assign bus.note_idx         = r_idx;

endmodule
